// File: rtl/zero_detect_scheduler_if.sv
// ---------------------------------------------------------------------------
// zero_detect_scheduler_if
// Requester-side bundle of the zero-detect scheduler.
//   req_in      : per-requester request levels (4)
//   data_in     : requester i word at [i*WIDTH +: WIDTH]
//   grant_out   : one-hot grant, held for the whole job
//   busy_out    : scheduler not idle
//   done_out    : one-cycle completion pulse
//   done_id_out : index of the completed requester
//   hits_out    : detector hit count of the completed job
// master = requester side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface zero_detect_scheduler_if #(
   parameter int WIDTH = 8
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [3:0]           req_in;
   logic [4*WIDTH-1:0]   data_in;
   logic [3:0]           grant_out;
   logic                 busy_out;
   logic                 done_out;
   logic [1:0]           done_id_out;
   logic [CNT_W-1:0]     hits_out;

   modport master (
      output req_in, data_in,
      input  grant_out, busy_out, done_out, done_id_out, hits_out
   );

   modport slave (
      input  req_in, data_in,
      output grant_out, busy_out, done_out, done_id_out, hits_out
   );
endinterface

// File: rtl/zero_detect_scheduler.sv
// ---------------------------------------------------------------------------
// zero_detect_scheduler
// Round-robin scheduler sharing one serial sequence detector among four
// requesters. A granted word is latched, the detector is cleared, the word is
// shifted in MSB-first and detector hits are counted and returned.
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   bus         : requester bundle (slave modport)
//   det_x_out   : serial bit to the detector
//   det_rst_out : active-low clear to the detector
//   det_y_in    : detector output
// MOORE=0 counts det_y_in during SHIFT; MOORE=1 shifts the window one cycle
// later (SHIFT cycles 1..WIDTH-1 plus DRAIN). Either way the window holds
// exactly WIDTH samples, so the counter never overflows CNT_W.
// ---------------------------------------------------------------------------
module zero_detect_scheduler #(
   parameter int WIDTH = 8,
   parameter bit MOORE = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   zero_detect_scheduler_if.slave  bus,
   output logic                    det_x_out,
   output logic                    det_rst_out,
   input  logic                    det_y_in
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      SHIFT = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t             state_r, state_nxt_s;
   logic [WIDTH-1:0]   shift_r, shift_nxt_s;
   logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_nxt_s;
   logic [CNT_W-1:0]   hits_r, hits_nxt_s;
   logic [CNT_W-1:0]   hits_out_r, hits_out_nxt_s;
   logic [1:0]         last_grant_r, last_grant_nxt_s;
   logic [1:0]         idx_r, idx_nxt_s;
   logic [1:0]         done_id_r, done_id_nxt_s;
   logic [3:0]         grant_r, grant_nxt_s;
   logic               busy_r, busy_nxt_s;
   logic               done_r, done_nxt_s;
   logic               det_x_r, det_x_nxt_s;
   logic               det_rst_r, det_rst_nxt_s;
   logic [2:0]         sel_s;
   logic               sample_s;

   // Round-robin select: {valid, index}. Scans from farthest to nearest so the
   // requester right after 'last' overwrites and wins; 'last' itself is last.
   function automatic logic [2:0] rr_select(input logic [3:0] req, input logic [1:0] last);
      logic [2:0] sel;
      logic [1:0] cand;
      sel = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         cand = last + 2'(k);
         if (req[cand]) begin
            sel = {1'b1, cand};
         end else begin
            sel = sel;
         end
      end
      return sel;
   endfunction

   // Pick the next requester and decide whether this cycle's det_y_in counts
   always_comb begin
      sel_s = rr_select(bus.req_in, last_grant_r);
      if (MOORE) begin
         sample_s = ((state_r == SHIFT) && (bit_cnt_r != {CNT_W{1'b0}})) || (state_r == DRAIN);
      end else begin
         sample_s = (state_r == SHIFT);
      end
   end

   // Next-state and next registered-output logic
   always_comb begin
      state_nxt_s      = state_r;
      shift_nxt_s      = shift_r;
      bit_cnt_nxt_s    = bit_cnt_r;
      hits_nxt_s       = hits_r + ((sample_s && det_y_in) ? CNT_W'(1) : CNT_W'(0));
      hits_out_nxt_s   = hits_out_r;
      last_grant_nxt_s = last_grant_r;
      idx_nxt_s        = idx_r;
      done_id_nxt_s    = done_id_r;
      grant_nxt_s      = grant_r;
      busy_nxt_s       = busy_r;
      done_nxt_s       = 1'b0;
      det_x_nxt_s      = det_x_r;
      det_rst_nxt_s    = det_rst_r;
      case (state_r)
         IDLE: begin
            if (sel_s[2]) begin
               state_nxt_s   = CLEAR;
               idx_nxt_s     = sel_s[1:0];
               grant_nxt_s   = 4'b0001 << sel_s[1:0];
               shift_nxt_s   = bus.data_in[sel_s[1:0]*WIDTH +: WIDTH];
               busy_nxt_s    = 1'b1;
               det_rst_nxt_s = 1'b0;
               det_x_nxt_s   = 1'b0;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CLEAR: begin
            // Release the detector and present the MSB in the first SHIFT cycle
            state_nxt_s   = SHIFT;
            det_rst_nxt_s = 1'b1;
            det_x_nxt_s   = shift_r[WIDTH-1];
            shift_nxt_s   = {shift_r[WIDTH-2:0], 1'b0};
            bit_cnt_nxt_s = {CNT_W{1'b0}};
            hits_nxt_s    = {CNT_W{1'b0}};
         end
         SHIFT: begin
            bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
            if (bit_cnt_r == CNT_W'(WIDTH - 1)) begin
               state_nxt_s = DRAIN;
               det_x_nxt_s = 1'b0;
            end else begin
               det_x_nxt_s = shift_r[WIDTH-1];
               shift_nxt_s = {shift_r[WIDTH-2:0], 1'b0};
            end
         end
         DRAIN: begin
            // hits_nxt_s already includes the final Moore sample
            state_nxt_s      = DONE;
            done_nxt_s       = 1'b1;
            done_id_nxt_s    = idx_r;
            hits_out_nxt_s   = hits_nxt_s;
            grant_nxt_s      = 4'b0000;
            last_grant_nxt_s = idx_r;
         end
         DONE: begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
         end
         default: begin
            state_nxt_s = IDLE;
            grant_nxt_s = 4'b0000;
            busy_nxt_s  = 1'b0;
            det_x_nxt_s = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any job and holds the detector cleared
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         shift_r      <= {WIDTH{1'b0}};
         bit_cnt_r    <= {CNT_W{1'b0}};
         hits_r       <= {CNT_W{1'b0}};
         hits_out_r   <= {CNT_W{1'b0}};
         last_grant_r <= 2'd3;
         idx_r        <= 2'd0;
         done_id_r    <= 2'd0;
         grant_r      <= 4'b0000;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         det_x_r      <= 1'b0;
         det_rst_r    <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         shift_r      <= shift_nxt_s;
         bit_cnt_r    <= bit_cnt_nxt_s;
         hits_r       <= hits_nxt_s;
         hits_out_r   <= hits_out_nxt_s;
         last_grant_r <= last_grant_nxt_s;
         idx_r        <= idx_nxt_s;
         done_id_r    <= done_id_nxt_s;
         grant_r      <= grant_nxt_s;
         busy_r       <= busy_nxt_s;
         done_r       <= done_nxt_s;
         det_x_r      <= det_x_nxt_s;
         det_rst_r    <= det_rst_nxt_s;
      end
   end

   assign bus.grant_out   = grant_r;
   assign bus.busy_out    = busy_r;
   assign bus.done_out    = done_r;
   assign bus.done_id_out = done_id_r;
   assign bus.hits_out    = hits_out_r;
   assign det_x_out       = det_x_r;
   assign det_rst_out     = det_rst_r;
endmodule

// File: tb/tb_zero_detect_scheduler.sv
// ---------------------------------------------------------------------------
// tb_zero_detect_scheduler
// Two schedulers (MOORE=0 and MOORE=1) run in lockstep on the same requests.
// DUT0 drives a bench detector: either y = ~x (Mealy, counts zeros) or a
// Mealy "00" pair detector. DUT1 sees a registered ~x (Moore, counts zeros).
// ---------------------------------------------------------------------------
module tb_zero_detect_scheduler;
   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]     req_v  = 4'b0000;
   logic [4*W-1:0] data_v = '0;
   logic           det_mode = 1'b0;

   zero_detect_scheduler_if #(.WIDTH(W)) bus0 ();
   zero_detect_scheduler_if #(.WIDTH(W)) bus1 ();
   assign bus0.req_in  = req_v;
   assign bus0.data_in = data_v;
   assign bus1.req_in  = req_v;
   assign bus1.data_in = data_v;

   logic x0, r0, y0, x1, r1, y1;

   zero_detect_scheduler #(.WIDTH(W), .MOORE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0),
      .det_x_out(x0), .det_rst_out(r0), .det_y_in(y0));

   zero_detect_scheduler #(.WIDTH(W), .MOORE(1'b1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .det_x_out(x1), .det_rst_out(r1), .det_y_in(y1));

   // Bench detector for DUT0: previous-bit-was-zero flag, cleared by det_rst
   logic prev_zero;
   always_ff @(posedge clk or negedge r0) begin
      if (!r0) prev_zero <= 1'b0;
      else     prev_zero <= ~x0;
   end
   assign y0 = det_mode ? (~x0 & prev_zero) : ~x0;

   // Moore-style detector for DUT1: output one cycle behind its input
   logic y1_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) y1_q <= 1'b0;
      else      y1_q <= ~x1;
   end
   assign y1 = y1_q;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   int last_m = 3;
   int grant_cyc = 0;
   int prev_grant_cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] req, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (req[(last + k) % 4]) return (last + k) % 4;
      end
      return 0;
   endfunction

   function automatic int zeros(input logic [W-1:0] w);
      int n = 0;
      for (int i = 0; i < W; i++) if (!w[i]) n++;
      return n;
   endfunction

   function automatic int pairs00(input logic [W-1:0] w);
      int n = 0;
      for (int i = 0; i < W - 1; i++) if (!w[i] && !w[i+1]) n++;
      return n;
   endfunction

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_dut0"}, 32'({bus0.grant_out, bus0.busy_out, bus0.done_out,
               bus0.done_id_out, bus0.hits_out, x0, r0}), 32'd0);
      check_eq({tag, "_dut1"}, 32'({bus1.grant_out, bus1.busy_out, bus1.done_out,
               bus1.done_id_out, bus1.hits_out, x1, r1}), 32'd0);
   endtask

   // Runs one job from a negedge; returns at the negedge of the DONE cycle.
   // abort_at >= 0 asserts reset in that SHIFT cycle instead.
   task automatic run_job(input logic [3:0] req, input logic [4*W-1:0] data,
                          input bit scramble, input int abort_at);
      int idx, t, exp0, exp1, done_cyc;
      logic [W-1:0] word;
      logic [3:0] g_exp;
      bit aborted;
      aborted = 1'b0;
      req_v  = req;
      data_v = data;
      idx   = rr_pick(req, last_m);
      g_exp = 4'b0001 << idx;
      word  = data[idx*W +: W];
      exp0  = det_mode ? pairs00(word) : zeros(word);
      exp1  = zeros(word);
      t = 0;
      while (bus0.grant_out == 4'b0000 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check_eq("grant_wait", 32'(t < 20), 32'd1);
      prev_grant_cyc = grant_cyc;
      grant_cyc = cyc;
      check_eq("grant0", 32'(bus0.grant_out), 32'(g_exp));
      check_eq("grant1", 32'(bus1.grant_out), 32'(g_exp));
      check_eq("clear_busy", 32'(bus0.busy_out), 32'd1);
      check_eq("clear_det", 32'({r0, x0, r1, x1}), 32'd0);
      if (scramble) begin
         data_v = $urandom;
         req_v  = 4'b0000;
      end
      for (int k = 0; k < W && !aborted; k++) begin
         @(negedge clk);
         if (abort_at == k) begin
            #1 rst = 1'b0;
            #1 check_reset_state("abort");
            req_v = 4'b0000;
            for (int h = 0; h < 3; h++) begin
               @(negedge clk);
               check_eq("abort_nodone", 32'({bus0.done_out, bus1.done_out}), 32'd0);
            end
            rst = 1'b1;
            last_m = 3;
            aborted = 1'b1;
         end else begin
            check_eq("shift_x0", 32'(x0), 32'(word[W-1-k]));
            check_eq("shift_x1", 32'(x1), 32'(word[W-1-k]));
            check_eq("shift_rst", 32'({r0, r1}), 32'd3);
            check_eq("shift_grant", 32'(bus0.grant_out), 32'(g_exp));
         end
      end
      if (!aborted) begin
         @(negedge clk);
         check_eq("drain", 32'({bus0.done_out, x0, r0}), 32'd1);
         @(negedge clk);
         done_cyc = cyc;
         check_eq("done_lat", 32'(done_cyc - grant_cyc), 32'(W + 2));
         check_eq("done0", 32'(bus0.done_out), 32'd1);
         check_eq("done1", 32'(bus1.done_out), 32'd1);
         check_eq("done_id0", 32'(bus0.done_id_out), 32'(idx));
         check_eq("done_id1", 32'(bus1.done_id_out), 32'(idx));
         check_eq("hits0", 32'(bus0.hits_out), 32'(exp0));
         check_eq("hits1", 32'(bus1.hits_out), 32'(exp1));
         check_eq("done_grant", 32'(bus0.grant_out), 32'd0);
         last_m = idx;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int any_grant;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b1;
      @(negedge clk);
      check_reset_state("idle_noreq");

      // Directed first job: zeros of 1011_0010 = 4
      det_mode = 1'b0;
      run_job(4'b0001, {24'h0, 8'b1011_0010}, 1'b0, -1);
      check_eq("t1_hits", 32'(bus0.hits_out), 32'd4);
      check_eq("t1_id", 32'(bus0.done_id_out), 32'd0);

      // All requesting: round-robin order and back-to-back period
      for (int j = 0; j < 5; j++) begin
         run_job(4'b1111, 32'h81_0F_3C_A5, 1'b0, -1);
         if (j > 0) check_eq("rr_period", 32'(grant_cyc - prev_grant_cyc), 32'(W + 4));
      end

      // "00" pair detector on 1100_1110 -> one pair
      det_mode = 1'b1;
      run_job(4'b0010, {16'h0, 8'hCE, 8'h0}, 1'b0, -1);
      check_eq("t3_hits", 32'(bus0.hits_out), 32'd1);

      // 0x0F: four zeros for both Mealy and Moore counting
      det_mode = 1'b0;
      run_job(4'b0100, {8'h0, 8'h0F, 16'h0}, 1'b0, -1);
      check_eq("t4_hits0", 32'(bus0.hits_out), 32'd4);
      check_eq("t4_hits1", 32'(bus1.hits_out), 32'd4);

      // Data and request change mid-job: latched word still counted, no new grant
      run_job(4'b0001, {24'h0, 8'b0000_0111}, 1'b1, -1);
      any_grant = 0;
      for (int h = 0; h < 15; h++) begin
         @(negedge clk);
         if (bus0.grant_out != 4'b0000) any_grant = 1;
      end
      check_eq("no_regrant", 32'(any_grant), 32'd0);

      // Abort a job on requester 2, then the pointer must restart at 0
      run_job(4'b0100, 32'h00_5A_00_00, 1'b0, 3);
      run_job(4'b0101, 32'h00_33_00_C3, 1'b0, -1);
      check_eq("ptr_reset", 32'(bus0.done_id_out), 32'd0);
      run_job(4'b0100, 32'h00_F0_00_00, 1'b0, -1);

      // Randomised jobs
      for (int j = 0; j < 20; j++) begin
         det_mode = 1'($urandom_range(0, 1));
         run_job(4'($urandom_range(1, 15)), $urandom, 1'b0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/zero_detect_scheduler.md
# zero_detect_scheduler

Round-robin scheduler sharing one serial sequence detector (zero_detector-style: serial bit in, one-bit detect out) among four requesters. Each granted requester's WIDTH-bit word is latched, the detector is cleared, the word is shifted into it MSB-first, and the number of detect-output hits is counted and returned with a one-cycle done pulse. Sits between the requester blocks and the single detector instance, which it fully controls.

## Interface
- WIDTH, 8, bits per job word (≥2).
- MOORE, 0, 0: detector output is Mealy, counted in the same cycle as its bit; 1: Moore, count window delayed by one cycle.
- CNT_W, $clog2(WIDTH+1), hit-counter width (derived, not overridden).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_in  in  4  per-requester request level.
- data_in  in  4*WIDTH  requester i word at [i*WIDTH +: WIDTH].
- grant_out  out  4  one-hot grant, held for the whole job.
- busy_out  out  1  high in any state except IDLE.
- done_out  out  1  one-cycle completion pulse.
- done_id_out  out  2  requester index of the completed job, held until next done.
- hits_out  out  CNT_W  hit count of the completed job, held until next done.
- det_x_out  out  1  serial bit to detector x_in.
- det_rst_out  out  1  active-low clear to detector rst.
- det_y_in  in  1  detector y_out.

## Operation
- Registered FSM: IDLE -> CLEAR -> SHIFT -> DRAIN -> DONE -> IDLE. All outputs registered.
- IDLE: if any req_in bit high, select the first requester scanning upward (mod 4) from last_grant+1; latch its word into the shift register, set grant_out, go CLEAR. Else stay.
- CLEAR (1 cycle): det_rst_out=0, det_x_out=0, hit counter cleared.
- SHIFT (WIDTH cycles): det_rst_out=1; det_x_out = word bit WIDTH-1 first, then down to bit 0, one per cycle; bit counter counts 0..WIDTH-1, exits on WIDTH-1.
- DRAIN (1 cycle): det_x_out=0; gives the Moore output its final sample.
- Counting window: MOORE=0 counts det_y_in in each SHIFT cycle; MOORE=1 counts in SHIFT cycles 2..WIDTH plus DRAIN. Window is exactly WIDTH samples; counter cannot exceed WIDTH, no saturation logic needed.
- DONE (1 cycle): done_out=1, done_id_out and hits_out updated, grant_out cleared, last_grant updated.
- Requests are levels; req_in or data_in changes after grant are ignored until the next IDLE. A requester still requesting after its done is re-eligible, but lower priority than the others by round-robin.

## Timing
- Reset (rst low, async): state IDLE, grant_out=0, busy_out=0, done_out=0, done_id_out=0, hits_out=0, det_x_out=0, det_rst_out=0 (detector held cleared), last_grant=3 so requester 0 wins first.
- Reset mid-job aborts it: no done pulse, no hits update; detector held cleared.
- Grant appears the cycle after req_in is sampled in IDLE; done_out rises WIDTH+2 cycles after grant_out rises; grant_out falls with done_out.
- Back-to-back jobs: next grant one cycle after DONE (via IDLE); job period WIDTH+4 cycles.
- Simultaneous requests: exactly one grant; others wait, none starved (max wait 3 jobs).
- det_rst_out low exactly one cycle per job (CLEAR), never during SHIFT/DRAIN.

## Test plan
- Reset then req_in=4'b0001, data0=8'b1011_0010, bench loops det_y_in = ~det_x_out, MOORE=0 -> grant 0001, det_x_out sequence 1,0,1,1,0,0,1,0, done_out 10 cycles after grant, hits_out=4, done_id_out=0.
- req_in=4'b1111 held, distinct words -> grants 0001,0010,0100,1000,0001 in order, each job 12 cycles apart, done_id_out 0,1,2,3,0.
- Real zero_detector instance, word 8'b1100_1110 -> hits_out equals golden model count; det_rst_out low one cycle before first bit.
- MOORE=1 with bench det_y_in registered copy of ~det_x_out, word 8'h0F -> hits_out=4; same word MOORE=0 with combinational loop -> hits_out=4.
- rst asserted during SHIFT cycle 3 -> all outputs to reset values immediately, no done pulse; after release with req_in=4'b0100 -> grant 0100 (pointer reset).
- data_in changed and req_in dropped mid-job -> job completes with originally latched word's count; no new grant afterward.
